lns_dmem_responder: RTL and testbench
=====================================

// Module: lns_dmem_responder
// PURPOSE
//   Data-memory responder serving load/store requests from the LNS pipeline's stage-3 initiator.
//   Replaces the combinational DMEM with a registered valid/ready request/response slave that inserts
//   WAIT_CYC wait states and flags out-of-range addresses.
//   Sits between the stage-3 memory port and a DEPTH-word 16-bit storage array.
// PARAMETERS
//   ADDR_W    16    request address width (word addresses)
//   DATA_W    16    data word width
//   DEPTH     1024  implemented words; valid addresses are 0..DEPTH-1
//   WAIT_CYC  2     wait states between request accept and response; 0..15 legal
// PORTS
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous, active-low reset
//   req_valid  in   1       initiator presents a request
//   req_ready  out  1       responder can accept a request this cycle
//   req_we     in   1       1 = store, 0 = load
//   req_addr   in   ADDR_W  word address
//   req_wdata  in   DATA_W  store data
//   rsp_valid  out  1       response available
//   rsp_ready  in   1       initiator consumes the response
//   rsp_rdata  out  DATA_W  load data; 0 for stores and for errors
//   rsp_err    out  1       1 = address >= DEPTH
// BEHAVIOUR
//   - Reset (reset=0, async): FSM=IDLE, wait counter=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//     captured request fields cleared. Array contents are not reset. req_ready rises on the first edge after release.
//   - States: IDLE, BUSY, RESP. req_ready=1 only in IDLE (see LNS_DMEM_B2B_EN).
//   - IDLE: accept when req_valid & req_ready at posedge; capture we/addr/wdata.
//     WAIT_CYC=0 -> go to RESP; else go to BUSY with counter=WAIT_CYC-1.
//   - BUSY: counter decrements each cycle; leave for RESP on the edge where counter==0.
//   - Access edge = edge entering RESP. Store: array[addr]<=wdata. Load: rsp_rdata<=array[addr].
//     Both happen only when addr<DEPTH. Otherwise: no write, rsp_err<=1, rsp_rdata<=0.
//   - Latency: rsp_valid is high exactly WAIT_CYC+1 cycles after the accept edge.
//   - RESP: rsp_valid, rsp_rdata and rsp_err stay stable until rsp_valid & rsp_ready at posedge.
//     On that edge: -> IDLE, rsp_valid<=0, rsp_rdata<=0, rsp_err<=0.
//   - req_* inputs are ignored outside the accept cycle. A request held across BUSY/RESP is not re-accepted
//     until req_ready returns.
//   - Load then store to the same address: the load returns the pre-store value, since transactions are serialised.
//   - addr comparison is unsigned, full ADDR_W. Addresses DEPTH..2^ADDR_W-1 return an error and never alias.
//   - Reset mid-transaction: a store not yet at its access edge is dropped. A store already written remains.
//   - Throughput without the optional feature: one transaction per WAIT_CYC+3 cycles minimum.
// CONFIGURATION
//   LNS_DMEM_B2B_EN  defined: in RESP, req_ready = rsp_ready. A request accepted on the same edge as the
//     response handshake goes straight to BUSY/RESP, bypassing IDLE. Throughput becomes WAIT_CYC+1 cycles
//     per transaction, and rsp_valid may stay high across back-to-back responses (new data on each handshake edge).
//   not defined: req_ready=1 only in IDLE; at least one IDLE cycle between responses.
// TESTING
//   1. Reset low mid-BUSY -> next cycle all outputs 0 and FSM IDLE; after release, req_ready=1 one edge later.
//   2. WAIT_CYC=2: store addr 5 data 16'h1234, then load addr 5 -> load rsp_rdata=16'h1234, rsp_err=0;
//      rsp_valid rises 3 cycles after each accept.
//   3. Load addr 16'h0400 with DEPTH=1024 -> rsp_err=1, rsp_rdata=0. A store there changes no location:
//      a load of addr 0 still returns its prior value.
//   4. Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable throughout, req_ready=0.
//      Raise rsp_ready -> IDLE next cycle.
//   5. WAIT_CYC=0: load addr 3 -> rsp_valid exactly 1 cycle after accept.
//   6. With LNS_DMEM_B2B_EN, req_valid and rsp_ready held high, 4 loads -> responses spaced WAIT_CYC+1 cycles
//      apart. Without the macro -> spaced WAIT_CYC+3.

Source files
------------

// File: rtl/lns_dmem_responder.sv
// Registered valid/ready data-memory responder for the LNS stage-3 port: WAIT_CYC wait states, range-checked access.
// Optional macro LNS_DMEM_B2B_EN lets a new request be accepted on the response handshake edge.
module lns_dmem_responder #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 1024,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
    localparam bit              ZERO_WAIT = (WAIT_CYC == 0);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state_reg;
    logic [3:0]          cnt_reg;
    logic                req_ready_reg;
    logic                rsp_valid_reg;
    logic                rsp_err_reg;
    logic                rdata_sel_reg;
    logic                cap_we_reg;
    logic [ADDR_W-1:0]   cap_addr_reg;
    logic [DATA_W-1:0]   cap_wdata_reg;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   mem_q_reg;

    logic                b2b_ready;
    logic                accept;
    logic                rsp_hs;
    logic                access_en;
    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic                acc_in_range;

`ifdef LNS_DMEM_B2B_EN
    assign b2b_ready = (state_reg == RESP) & rsp_ready;
`else
    assign b2b_ready = 1'b0;
`endif

    assign req_ready = req_ready_reg | b2b_ready;
    assign accept    = req_valid & req_ready;
    assign rsp_hs    = rsp_valid_reg & rsp_ready;

    // The access edge is the edge entering RESP; with zero wait states it coincides
    // with the accept edge, so the live request fields are used instead of the captured ones.
    always_comb begin
        access_en = 1'b0;
        acc_we    = cap_we_reg;
        acc_addr  = cap_addr_reg;
        acc_wdata = cap_wdata_reg;
        case (state_reg)
            IDLE: begin
                if (accept && ZERO_WAIT) begin
                    access_en = 1'b1;
                    acc_we    = req_we;
                    acc_addr  = req_addr;
                    acc_wdata = req_wdata;
                end
            end
            BUSY: begin
                access_en = (cnt_reg == 4'd0);
            end
            RESP: begin
                if (rsp_hs && accept && ZERO_WAIT) begin
                    access_en = 1'b1;
                    acc_we    = req_we;
                    acc_addr  = req_addr;
                    acc_wdata = req_wdata;
                end
            end
            default: begin
                access_en = 1'b0;
            end
        endcase
    end

    assign acc_in_range = ({1'b0, acc_addr} < DEPTH_LIM);

    // Storage is deliberately kept out of the reset domain so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (access_en && acc_in_range) begin
            if (acc_we) begin
                mem[acc_addr[IDX_W-1:0]] <= acc_wdata;
            end else begin
                mem_q_reg <= mem[acc_addr[IDX_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rdata_sel_reg <= 1'b0;
            cap_we_reg    <= 1'b0;
            cap_addr_reg  <= '0;
            cap_wdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        cap_we_reg    <= req_we;
                        cap_addr_reg  <= req_addr;
                        cap_wdata_reg <= req_wdata;
                        req_ready_reg <= 1'b0;
                        if (ZERO_WAIT) begin
                            state_reg     <= RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= ~acc_in_range;
                            rdata_sel_reg <= ~acc_we & acc_in_range;
                        end else begin
                            state_reg <= BUSY;
                            cnt_reg   <= WAIT_INIT;
                        end
                    end else begin
                        // ready rises one edge after IDLE is entered
                        req_ready_reg <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= ~acc_in_range;
                        rdata_sel_reg <= ~acc_we & acc_in_range;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        if (accept) begin
                            cap_we_reg    <= req_we;
                            cap_addr_reg  <= req_addr;
                            cap_wdata_reg <= req_wdata;
                            if (ZERO_WAIT) begin
                                rsp_valid_reg <= 1'b1;
                                rsp_err_reg   <= ~acc_in_range;
                                rdata_sel_reg <= ~acc_we & acc_in_range;
                            end else begin
                                state_reg     <= BUSY;
                                cnt_reg       <= WAIT_INIT;
                                rsp_valid_reg <= 1'b0;
                                rsp_err_reg   <= 1'b0;
                                rdata_sel_reg <= 1'b0;
                            end
                        end else begin
                            state_reg     <= IDLE;
                            rsp_valid_reg <= 1'b0;
                            rsp_err_reg   <= 1'b0;
                            rdata_sel_reg <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rdata_sel_reg ? mem_q_reg : '0;

endmodule

// File: tb/tb_lns_dmem_responder.sv
// Scoreboard bench for lns_dmem_responder: one WAIT_CYC=2 instance and one WAIT_CYC=0 instance.
module tb_lns_dmem_responder;

    localparam int W0    = 2;
    localparam int W1    = 0;
    localparam int DEPTH = 1024;
`ifdef LNS_DMEM_B2B_EN
    localparam int SPACING = W0 + 1;
`else
    localparam int SPACING = W0 + 3;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [15:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [15:0] rsp_rdata [2];
    logic        rsp_err   [2];

    lns_dmem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .WAIT_CYC(W0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    lns_dmem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .WAIT_CYC(W1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        sbq[$];
    logic [15:0] model [2][DEPTH];

    // Reference model: computes the expected response and updates the bench's own memory image.
    function automatic void expect_txn(int d, bit we, logic [15:0] addr, logic [15:0] wdata);
        exp_t e;
        if (int'(addr) >= DEPTH) begin
            e.rdata = 16'h0000;
            e.err   = 1'b1;
        end else begin
            e.err = 1'b0;
            if (we) begin
                model[d][addr] = wdata;
                e.rdata = 16'h0000;
            end else begin
                e.rdata = model[d][addr];
            end
        end
        sbq.push_back(e);
    endfunction

    // Drives one request and returns when the response is first visible (not yet acknowledged).
    task automatic txn(input int d, input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                       output int lat, output logic [15:0] rd, output logic err, output bit ok);
        int n;
        ok  = 1'b1;
        lat = 0;
        rd  = 16'h0000;
        err = 1'b0;
        @(negedge clk);
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        rsp_ready[d] = 1'b0;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready[d] !== 1'b1) begin
            ok = 1'b0;
            req_valid[d] = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat = 1;
        while (rsp_valid[d] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (rsp_valid[d] !== 1'b1) ok = 1'b0;
        rd  = rsp_rdata[d];
        err = rsp_err[d];
    endtask

    task automatic ack(input int d);
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 16'h0; req_wdata[d] = 16'h0;
            rsp_ready[d] = 1'b0;
        end
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b0 || rsp_rdata[d] !== 16'h0 || rsp_err[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got valid=%b ready=%b rdata=%h err=%b expected all 0",
                         d, rsp_valid[d], req_ready[d], rsp_rdata[d], rsp_err[d]);
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready_early got %b expected 0", req_ready[0]);
        end
        @(negedge clk);
        checks++;
        if (req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b expected 1", req_ready[0]);
        end
    endtask

    task automatic test_store_load;
        req_t tbl[$];
        int lat; logic [15:0] rd; logic er; bit ok; exp_t e;
        tbl.push_back('{1'b1, 16'h0005, 16'h1234});
        tbl.push_back('{1'b0, 16'h0005, 16'h0000});
        tbl.push_back('{1'b1, 16'h0007, 16'hAAAA});
        tbl.push_back('{1'b0, 16'h0007, 16'h0000});
        foreach (tbl[i]) begin
            expect_txn(0, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            txn(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, rd, er, ok);
            ack(0);
            e = sbq.pop_front();
            checks++;
            if (!ok || lat != W0 + 1) begin
                errors++;
                $display("FAIL store_load_latency[%0d] got %0d expected %0d", i, lat, W0 + 1);
            end
            checks++;
            if (rd !== e.rdata || er !== e.err) begin
                errors++;
                $display("FAIL store_load_data[%0d] got rdata=%h err=%b expected rdata=%h err=%b",
                         i, rd, er, e.rdata, e.err);
            end
            $display("txn store_load[%0d] we=%0d addr=%h rdata=%h err=%b lat=%0d", i, tbl[i].we, tbl[i].addr, rd, er, lat);
        end
    endtask

    task automatic test_out_of_range;
        req_t tbl[$];
        int lat; logic [15:0] rd; logic er; bit ok; exp_t e;
        tbl.push_back('{1'b1, 16'h0000, 16'hBEEF});
        tbl.push_back('{1'b0, 16'h0400, 16'h0000});
        tbl.push_back('{1'b1, 16'h0400, 16'hDEAD});
        tbl.push_back('{1'b0, 16'h0000, 16'h0000});
        tbl.push_back('{1'b1, 16'h03FF, 16'h7FFF});
        tbl.push_back('{1'b0, 16'h03FF, 16'h0000});
        tbl.push_back('{1'b1, 16'hFC05, 16'h1111});
        tbl.push_back('{1'b0, 16'hFFFF, 16'h0000});
        tbl.push_back('{1'b0, 16'h0005, 16'h0000});
        foreach (tbl[i]) begin
            expect_txn(0, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            txn(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, rd, er, ok);
            ack(0);
            e = sbq.pop_front();
            checks++;
            if (!ok || rd !== e.rdata || er !== e.err) begin
                errors++;
                $display("FAIL range[%0d] addr=%h got rdata=%h err=%b ok=%0d expected rdata=%h err=%b",
                         i, tbl[i].addr, rd, er, ok, e.rdata, e.err);
            end
            $display("txn range[%0d] we=%0d addr=%h rdata=%h err=%b", i, tbl[i].we, tbl[i].addr, rd, er);
        end
    endtask

    task automatic test_stall;
        int lat; logic [15:0] rd; logic er; bit ok; exp_t e;
        expect_txn(0, 1'b0, 16'h0005, 16'h0000);
        txn(0, 1'b0, 16'h0005, 16'h0000, lat, rd, er, ok);
        e = sbq.pop_front();
        checks++;
        if (!ok || rd !== e.rdata || er !== e.err) begin
            errors++;
            $display("FAIL stall_first got rdata=%h err=%b expected rdata=%h err=%b", rd, er, e.rdata, e.err);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== e.rdata || rsp_err[0] !== e.err || req_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d] got valid=%b rdata=%h err=%b ready=%b expected valid=1 rdata=%h err=%b ready=0",
                         k, rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0], e.rdata, e.err);
            end
        end
        ack(0);
        checks++;
        if (rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 16'h0 || rsp_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got valid=%b rdata=%h err=%b expected 0 0 0", rsp_valid[0], rsp_rdata[0], rsp_err[0]);
        end
        $display("txn stall load addr=0005 rdata=%h held 5 cycles", rd);
    endtask

    task automatic test_wait0;
        req_t tbl[$];
        int lat; logic [15:0] rd; logic er; bit ok; exp_t e;
        tbl.push_back('{1'b1, 16'h0003, 16'h0BAD});
        tbl.push_back('{1'b0, 16'h0003, 16'h0000});
        tbl.push_back('{1'b0, 16'h0400, 16'h0000});
        foreach (tbl[i]) begin
            expect_txn(1, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            txn(1, tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, rd, er, ok);
            ack(1);
            e = sbq.pop_front();
            checks++;
            if (!ok || lat != W1 + 1) begin
                errors++;
                $display("FAIL wait0_latency[%0d] got %0d expected %0d", i, lat, W1 + 1);
            end
            checks++;
            if (rd !== e.rdata || er !== e.err) begin
                errors++;
                $display("FAIL wait0_data[%0d] got rdata=%h err=%b expected rdata=%h err=%b", i, rd, er, e.rdata, e.err);
            end
            $display("txn wait0[%0d] we=%0d addr=%h rdata=%h err=%b lat=%0d", i, tbl[i].we, tbl[i].addr, rd, er, lat);
        end
    endtask

    task automatic test_reset_mid_busy;
        int n; int lat; logic [15:0] rd; logic er; bit ok; exp_t e;
        @(negedge clk);
        req_we[0] = 1'b1; req_addr[0] = 16'h0007; req_wdata[0] = 16'h5555; req_valid[0] = 1'b1;
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy_accept got ready=%b expected 1", req_ready[0]);
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0 || rsp_rdata[0] !== 16'h0 || rsp_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_busy_reset got valid=%b ready=%b rdata=%h err=%b expected all 0",
                     rsp_valid[0], req_ready[0], rsp_rdata[0], rsp_err[0]);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_busy_release_early got ready=%b expected 0", req_ready[0]);
        end
        @(negedge clk);
        checks++;
        if (req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy_release got ready=%b expected 1", req_ready[0]);
        end
        // the interrupted store must not have landed: model still holds the earlier value
        expect_txn(0, 1'b0, 16'h0007, 16'h0000);
        txn(0, 1'b0, 16'h0007, 16'h0000, lat, rd, er, ok);
        ack(0);
        e = sbq.pop_front();
        checks++;
        if (!ok || rd !== e.rdata || er !== e.err) begin
            errors++;
            $display("FAIL mid_busy_dropped_store got rdata=%h err=%b expected rdata=%h err=%b", rd, er, e.rdata, e.err);
        end
        $display("txn mid_busy load addr=0007 rdata=%h", rd);
    endtask

    task automatic test_back_to_back;
        logic [15:0] addrs [4];
        int issued; int got; int last; int cyc;
        exp_t e;
        addrs[0] = 16'h0005; addrs[1] = 16'h0000; addrs[2] = 16'h03FF; addrs[3] = 16'h0007;
        issued = 0; got = 0; last = -1;
        @(negedge clk);
        rsp_ready[0] = 1'b1;
        for (cyc = 0; cyc < 100 && got < 4; cyc++) begin
            if (rsp_valid[0] === 1'b1) begin
                e = sbq.pop_front();
                checks++;
                if (rsp_rdata[0] !== e.rdata || rsp_err[0] !== e.err) begin
                    errors++;
                    $display("FAIL b2b_data[%0d] got rdata=%h err=%b expected rdata=%h err=%b",
                             got, rsp_rdata[0], rsp_err[0], e.rdata, e.err);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != SPACING) begin
                        errors++;
                        $display("FAIL b2b_spacing[%0d] got %0d expected %0d", got, cyc - last, SPACING);
                    end
                end
                $display("txn b2b[%0d] cycle=%0d rdata=%h", got, cyc, rsp_rdata[0]);
                last = cyc;
                got++;
            end
            if (issued < 4) begin
                req_we[0]    = 1'b0;
                req_addr[0]  = addrs[issued];
                req_valid[0] = 1'b1;
                if (req_ready[0] === 1'b1) begin
                    expect_txn(0, 1'b0, addrs[issued], 16'h0000);
                    issued++;
                end
            end else begin
                req_valid[0] = 1'b0;
            end
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b0;
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL b2b_count got %0d expected 4", got);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_out_of_range();
        test_stall();
        test_wait0();
        test_reset_mid_busy();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
